// File: rtl/monpro_hs.sv
// Radix-2 bit-serial Montgomery multiplier: U = A*B*2^-DATAWIDTH mod N, fully reduced.
// Operands in over a start/ready handshake, result out over o_valid/o_ready with backpressure.
module monpro_hs #(
    parameter int unsigned DATAWIDTH = 256
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    output logic                 ready,
    input  logic [DATAWIDTH-1:0] i_A,
    input  logic [DATAWIDTH-1:0] i_B,
    input  logic [DATAWIDTH-1:0] i_N,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [DATAWIDTH-1:0] o_U
);

    localparam int unsigned UW = DATAWIDTH + 1;
    localparam int unsigned SW = DATAWIDTH + 2;
    localparam int unsigned CW = $clog2(DATAWIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [DATAWIDTH-1:0]   r_A;
    logic [DATAWIDTH-1:0]   r_B;
    logic [DATAWIDTH-1:0]   r_N;
    logic [UW-1:0]          r_U;
    logic [CW-1:0]          cnt;

    logic [SW-1:0]          s_add_b;
    logic [SW-1:0]          s_add_n;
    logic [UW-1:0]          u_next;
    logic                   u_ge_n;
    logic [DATAWIDTH-1:0]   u_red;

    assign ready = (state == IDLE);

    // Merged add-B/add-N iteration; U < 2N keeps every sum inside DATAWIDTH+2 bits.
    always_comb begin
        s_add_b = SW'(r_U) + (r_A[0] ? SW'(r_B) : SW'(0));
        s_add_n = s_add_b + (s_add_b[0] ? SW'(r_N) : SW'(0));
        u_next  = UW'(s_add_n >> 1);
    end

    // Final conditional subtract on the registered result of the last iteration.
    always_comb begin
        u_ge_n = (r_U >= UW'(r_N));
        u_red  = DATAWIDTH'(r_U - UW'(r_N));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            r_A     <= '0;
            r_B     <= '0;
            r_N     <= '0;
            r_U     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_U     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r_A   <= i_A;
                        r_B   <= i_B;
                        r_N   <= i_N;
                        r_U   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == CW'(DATAWIDTH)) begin
                        o_U     <= u_ge_n ? u_red : r_U[DATAWIDTH-1:0];
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end else begin
                        r_U <= u_next;
                        r_A <= r_A >> 1;
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
